// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM duty-cycle capture with tick-sampled counters and serial divider
// High time and period are counted in prescaled ticks and converted to a PWM_WIDTH-bit duty value.
module pwm_capture #(
  parameter int CLOCK_PRESCALER = 24,
  parameter int PWM_WIDTH       = 12,
  parameter int COUNT_WIDTH     = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   pwm_in,
  output logic [PWM_WIDTH-1:0]   duty_value,
  output logic                   duty_valid,
  output logic [COUNT_WIDTH-1:0] high_count,
  output logic [COUNT_WIDTH-1:0] period_count,
  output logic                   signal_lost
);

  localparam int PSW = (CLOCK_PRESCALER > 1) ? $clog2(CLOCK_PRESCALER) : 1;
  localparam int BCW = (PWM_WIDTH > 1) ? $clog2(PWM_WIDTH) : 1;
  localparam logic [PSW-1:0]         PS_LAST  = PSW'(CLOCK_PRESCALER - 1);
  localparam logic [BCW-1:0]         BIT_LAST = BCW'(PWM_WIDTH - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, MEASURE, DIVIDE} state_t;

  state_t                 state_q;
  logic                   sync1_q, sync2_q, p_q, armed_q;
  logic [PSW-1:0]         presc_q, presc_d;
  logic [COUNT_WIDTH-1:0] pcnt_q, pcnt_d, hcnt_q, hcnt_d;
  logic [COUNT_WIDTH-1:0] div_q, rem_q, rem_d;
  logic [COUNT_WIDTH:0]   rem_sh;
  logic [PWM_WIDTH-1:0]   quo_q, quo_d, duty_q;
  logic [BCW-1:0]         bit_q;
  logic                   sat_q, valid_q, lost_q;
  logic [COUNT_WIDTH-1:0] hc_q, pc_q;
  logic                   tick, rise, timeout, ge;

  assign duty_value   = duty_q;
  assign duty_valid   = valid_q;
  assign high_count   = hc_q;
  assign period_count = pc_q;
  assign signal_lost  = lost_q;

  always_comb begin
    tick    = (presc_q == PS_LAST);
    rise    = tick && sync2_q && !p_q;
    presc_d = tick ? '0 : presc_q + 1'b1;
    pcnt_d  = pcnt_q;
    hcnt_d  = hcnt_q;
    if (rise) begin
      pcnt_d = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
      hcnt_d = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    end else if (tick) begin
      if (pcnt_q != CNT_MAX) pcnt_d = pcnt_q + 1'b1;
      if (sync2_q && hcnt_q != CNT_MAX) hcnt_d = hcnt_q + 1'b1;
    end
    // Fires only on the tick that brings pcnt to saturation, so it cannot repeat while held there.
    timeout = tick && !rise && (pcnt_q == CNT_MAX - 1'b1) &&
              (state_q == MEASURE || (state_q == IDLE && armed_q));
    rem_sh = {rem_q, 1'b0};
    ge     = (rem_sh >= {1'b0, div_q});
    rem_d  = ge ? COUNT_WIDTH'(rem_sh - {1'b0, div_q}) : COUNT_WIDTH'(rem_sh);
    quo_d  = {quo_q[PWM_WIDTH-2:0], ge};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      p_q     <= 1'b0;
      armed_q <= 1'b0;
      presc_q <= '0;
      pcnt_q  <= '0;
      hcnt_q  <= '0;
      div_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      bit_q   <= '0;
      sat_q   <= 1'b0;
      duty_q  <= '0;
      valid_q <= 1'b0;
      lost_q  <= 1'b1;
      hc_q    <= '0;
      pc_q    <= '0;
    end else begin
      sync1_q <= pwm_in;
      sync2_q <= sync1_q;
      presc_q <= presc_d;
      if (tick) p_q <= sync2_q;
      pcnt_q  <= pcnt_d;
      hcnt_q  <= hcnt_d;
      valid_q <= 1'b0;
      if (timeout) begin
        lost_q  <= 1'b1;
        duty_q  <= sync2_q ? '1 : '0;
        valid_q <= 1'b1;
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (rise) begin
              armed_q <= 1'b1;
              state_q <= MEASURE;
            end
          end
          MEASURE: begin
            if (rise) begin
              pc_q    <= pcnt_q;
              hc_q    <= hcnt_q;
              div_q   <= pcnt_q;
              rem_q   <= hcnt_q;
              quo_q   <= '0;
              bit_q   <= '0;
              sat_q   <= (hcnt_q >= pcnt_q);
              state_q <= DIVIDE;
            end
          end
          DIVIDE: begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            bit_q <= bit_q + 1'b1;
            if (bit_q == BIT_LAST) begin
              duty_q  <= sat_q ? '1 : quo_d;
              valid_q <= 1'b1;
              lost_q  <= 1'b0;
              state_q <= MEASURE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures the duty cycle of an external PWM input and produces a value on the same scale that the PWM generator accepts as its load value. Typical uses are host backlight-dimming input and fan-tach loopback checks. The input is synchronised and sampled on a prescaled tick. High time and period are counted in ticks, and duty is computed by an iterative divider as high·2^PWM_WIDTH/period. A stuck input line is reported as signal loss with a 0% or 100% duty value.

## Interface
- CLOCK_PRESCALER, 24: clocks per sample tick; must be ≥ 2.
- PWM_WIDTH, 12: width of the duty result.
- COUNT_WIDTH, 16: width of the tick counters; sets the timeout.
- clock  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- pwm_in  in  1  asynchronous PWM input.
- duty_value  out  PWM_WIDTH  latest duty result.
- duty_valid  out  1  one-clock strobe when duty_value updates.
- high_count  out  COUNT_WIDTH  high ticks of the last complete period.
- period_count  out  COUNT_WIDTH  ticks of the last complete period.
- signal_lost  out  1  no complete period seen since reset or since the last timeout.

## Operation
- **Input path**
  - pwm_in passes through a 2-FF synchroniser.
  - The prescaler counts 0..CLOCK_PRESCALER-1; a tick occurs when it equals CLOCK_PRESCALER-1.
  - On each tick the synchronised level s is sampled and compared with the previous sample p.
  - A rising edge is s=1, p=0. Activity between ticks is invisible to the block.
- **Counters, per tick**
  - On a rising edge: pcnt←1, hcnt←1.
  - Otherwise: pcnt←pcnt+1 and hcnt←hcnt+s, both saturating at all-ones.
- **FSM states: IDLE, MEASURE, DIVIDE**
  - IDLE:
    - A rising edge goes to MEASURE; nothing is captured.
  - MEASURE:
    - A rising edge captures the pre-update pcnt/hcnt into period_count/high_count, loads the divider and goes to DIVIDE.
  - DIVIDE:
    - A restoring divider computes (hcnt<<PWM_WIDTH)/pcnt, one quotient bit per clock, over PWM_WIDTH clocks.
    - It then writes duty_value, pulses duty_valid, clears signal_lost and returns to MEASURE.
    - Ticks and counters keep running during DIVIDE.
    - A rising edge during DIVIDE restarts the counters; it is not captured.
- **Timeout**
  - Applies in MEASURE or IDLE (after the first edge) when pcnt reaches all-ones on a tick without a rising edge.
  - signal_lost←1.
  - duty_value←all-ones if s=1, else 0.
  - duty_valid pulses once.
  - State goes to IDLE; the counters hold at saturation.
  - No further strobes until a measurement completes.
- **Arithmetic**
  - Maximum measurable period is 2^COUNT_WIDTH−2 ticks.
  - hcnt<pcnt always holds at capture, so the quotient fits PWM_WIDTH bits.
  - The result is truncated, not rounded.
  - The quotient saturates to all-ones if hcnt≥pcnt (defensive).
- **Reset**, any cycle including mid-DIVIDE:
  - FSM→IDLE; prescaler, counters, p, duty_value, duty_valid, high_count and period_count→0.
  - signal_lost→1.
  - A divide in progress is discarded with no strobe.

## Timing
- Synchroniser latency is 2 clocks; tick quantisation adds 0..CLOCK_PRESCALER−1 clocks.
- Capture tick at clock edge T:
  - high_count/period_count are valid from T+1.
  - duty_value updates and duty_valid is high for exactly the one cycle at T+PWM_WIDTH+1.
- If PWM_WIDTH+2 ≤ 2·CLOCK_PRESCALER, every period of 2 or more ticks is measured with no drops.
- All outputs are registered.
- duty_valid never asserts on two consecutive clocks.

## Test plan
Bench parameters: CLOCK_PRESCALER=4, PWM_WIDTH=8, COUNT_WIDTH=8.
- **Startup:** release reset with pwm_in low.
  - Outputs are 0 and signal_lost=1.
  - The first rising edge produces no duty_valid.
- **Steady measurement:** period 100 ticks, high 25 ticks.
  - From the second edge onward: period_count=100, high_count=25, duty_value=64.
  - duty_valid fires once per period, 9 clocks after the capture tick.
- **Narrow duty:** high 1 tick, period 3 ticks → duty_value=85, with no dropped strobes over 20 periods.
- **Timeout:** lock at period 50, then hold pwm_in high.
  - When pcnt reaches 255: signal_lost=1, duty_value=255, one strobe.
  - Repeat with pwm_in held low → duty_value=0.
  - Restarting the PWM needs two edges before a new valid result, which clears signal_lost.
- **Reset mid-divide:** assert reset on the third DIVIDE clock.
  - Next cycle: all outputs 0, signal_lost=1, no duty_valid.
  - Normal measurement resumes afterwards.
- **Period change and glitch:** switch from 100/25 to 50/40 ticks.
  - The results that follow are 64 and 204.
  - A 1-clock pulse placed between ticks causes no strobe and no counter change.
